// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg
//   Shared types and encodings for the external bus controller slice.
//   - state_t : controller FSM states (IDLE / REQ / RELEASE)
//   - chan_t  : requesting channel id (instruction fetch or data access)
//   - EXT_*   : ext_rw bus command encodings
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    CH_FETCH = 1'b0,
    CH_MEM   = 1'b1
  } chan_t;

  localparam logic [1:0] EXT_IDLE  = 2'b00;
  localparam logic [1:0] EXT_READ  = 2'b01;
  localparam logic [1:0] EXT_WRITE = 2'b10;

endpackage

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter
//   Two-requester alternating-priority arbiter. On a collision the channel
//   that was not granted last wins; a lone request always wins.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   fetchReq    : instruction fetch request level
//   memReq      : data access request level
//   grantEn     : the controller is taking the grant this cycle
//   grantValid  : at least one request pending
//   grantCh     : channel that would be granted this cycle
module ext_bus_arbiter
  import ext_bus_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  fetchReq,
  input  logic  memReq,
  input  logic  grantEn,
  output logic  grantValid,
  output chan_t grantCh
);

  chan_t lastGrant;

  assign grantValid = fetchReq | memReq;

  // Reset to "fetch" so the data channel wins the first collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant <= CH_FETCH;
    end else if (grantEn && grantValid) begin
      lastGrant <= grantCh;
    end
  end

  always_comb begin
    grantCh = CH_FETCH;
    if (fetchReq && memReq) begin
      grantCh = (lastGrant == CH_FETCH) ? CH_MEM : CH_FETCH;
    end else if (memReq) begin
      grantCh = CH_MEM;
    end
  end

endmodule

// File: rtl/ext_bus_controller.sv
// ext_bus_controller
//   External memory exchange controller. Arbitrates fetch and data channels
//   onto one external bus and runs a four-phase ready handshake:
//   IDLE -> REQ (wait ready=1) -> RELEASE (wait ready=0) -> IDLE + ack.
// Parameters: DATA_W, ADDR_W, TIMEOUT_CYC (timeout build only).
// Ports:
//   clk, rst                       : clock, async active-high reset
//   fetch_req/addr, fetch_ack/data : instruction fetch channel
//   mem_req/we/addr/wdata          : data load/store request
//   mem_ack/rdata/err              : data completion; mem_err also qualifies fetch_ack
//   ext_addr/wdata/oe/rw           : external bus drive (rw 00 idle, 01 read, 10 write)
//   ext_rdata, ext_ready           : external read data and ready strobe
//   busy                           : high whenever the FSM is not in IDLE
// Build option: EXT_BUS_TIMEOUT_EN adds a handshake timeout that aborts the
//   access and acks with mem_err=1; without it mem_err is tied to 0.
module ext_bus_controller
  import ext_bus_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  output logic              ext_oe,
  input  logic [DATA_W-1:0] ext_rdata,
  output logic [1:0]        ext_rw,
  input  logic              ext_ready,
  output logic              busy
);

  state_t state, nextState;
  chan_t  grantCh, curCh;
  logic   grantValid;
  logic   takeGrant, readyHit, finish, timedOut, timeoutHit;
  logic   grantIsStore;

  ext_bus_arbiter uArbiter (
    .clk       (clk),
    .rst       (rst),
    .fetchReq  (fetch_req),
    .memReq    (mem_req),
    .grantEn   (takeGrant),
    .grantValid(grantValid),
    .grantCh   (grantCh)
  );

  assign grantIsStore = (grantCh == CH_MEM) && mem_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Ready has priority over a timeout landing on the same edge.
  always_comb begin
    nextState = state;
    takeGrant = 1'b0;
    readyHit  = 1'b0;
    finish    = 1'b0;
    timedOut  = 1'b0;
    case (state)
      IDLE: begin
        if (grantValid) begin
          takeGrant = 1'b1;
          nextState = REQ;
        end
      end
      REQ: begin
        if (ext_ready) begin
          readyHit  = 1'b1;
          nextState = RELEASE;
        end else if (timeoutHit) begin
          timedOut  = 1'b1;
          nextState = IDLE;
        end
      end
      RELEASE: begin
        if (!ext_ready) begin
          finish    = 1'b1;
          nextState = IDLE;
        end else if (timeoutHit) begin
          timedOut  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Registered bus drive, read capture and ack pulses. ext_rw still holds the
  // granted command when ready arrives, so it tells a read from a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curCh      <= CH_FETCH;
      ext_rw     <= EXT_IDLE;
      ext_oe     <= 1'b0;
      ext_addr   <= '0;
      ext_wdata  <= '0;
      fetch_ack  <= 1'b0;
      mem_ack    <= 1'b0;
      fetch_data <= '0;
      mem_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      fetch_ack <= 1'b0;
      mem_ack   <= 1'b0;
      busy      <= (nextState != IDLE);
      if (takeGrant) begin
        curCh     <= grantCh;
        ext_addr  <= (grantCh == CH_MEM) ? mem_addr : fetch_addr;
        ext_rw    <= grantIsStore ? EXT_WRITE : EXT_READ;
        ext_oe    <= grantIsStore;
        ext_wdata <= grantIsStore ? mem_wdata : '0;
      end
      if (readyHit) begin
        ext_rw <= EXT_IDLE;
        ext_oe <= 1'b0;
        if (ext_rw == EXT_READ) begin
          if (curCh == CH_FETCH) begin
            fetch_data <= ext_rdata;
          end else begin
            mem_rdata <= ext_rdata;
          end
        end
      end
      if (finish || timedOut) begin
        ext_rw <= EXT_IDLE;
        ext_oe <= 1'b0;
        if (curCh == CH_FETCH) begin
          fetch_ack <= 1'b1;
        end else begin
          mem_ack <= 1'b1;
        end
      end
    end
  end

`ifdef EXT_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] toCount;
  logic             errReg;

  // Count value TIMEOUT_CYC-1 marks the last wait cycle, so the abort lands
  // on the edge that closes the TIMEOUT_CYC-th cycle of REQ or RELEASE.
  assign timeoutHit = (toCount == CNT_W'(TIMEOUT_CYC - 1));
  assign mem_err    = errReg;

  // Restart the count on entry to REQ and to RELEASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCount <= '0;
      errReg  <= 1'b0;
    end else begin
      errReg <= timedOut;
      if (takeGrant || readyHit) begin
        toCount <= '0;
      end else if (state != IDLE) begin
        toCount <= toCount + 1'b1;
      end
    end
  end
`else
  logic unusedTimeoutCfg;

  assign timeoutHit       = 1'b0;
  assign mem_err          = 1'b0;
  assign unusedTimeoutCfg = (TIMEOUT_CYC > 0);
`endif

endmodule
